// File: rtl/mc_control_fsm_if.sv
// Control/status bundle between the multicycle RISC-V controller and its datapath.
// The controller side takes the master modport; the datapath (or a bench) takes slave.
interface mc_control_fsm_if #(
    parameter int ALUCTRL_W = 4
);
    logic [6:0]           op;
    logic [2:0]           funct3;
    logic                 funct7b5;
    logic                 Zero;
    logic                 Lt;
    logic                 Ltu;
    logic                 mem_ready;

    logic                 MemRead;
    logic                 MemWrite;
    logic                 AdrSrc;
    logic                 IRWrite;
    logic                 PCWrite;
    logic                 RegWrite;
    logic [1:0]           ResultSrc;
    logic [1:0]           ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [2:0]           ImmSrc;
    logic [ALUCTRL_W-1:0] ALUControl;
    logic                 trap;
    logic [3:0]           state_o;

    modport master (
        input  op, funct3, funct7b5, Zero, Lt, Ltu, mem_ready,
        output MemRead, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, trap, state_o
    );

    modport slave (
        output op, funct3, funct7b5, Zero, Lt, Ltu, mem_ready,
        input  MemRead, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, trap, state_o
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I main controller: fetch/decode/execute sequencing, ALU decode,
// memory-wait timeout and a sticky trap state for illegal opcodes or stalled memory.
module mc_control_fsm #(
    parameter int ALUCTRL_W   = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    mc_control_fsm_if.master bus
);

    generate
        if (ALUCTRL_W < 4) begin : g_bad_aluctrl_w
            $error("mc_control_fsm: ALUCTRL_W must be at least 4");
        end
        if ((MEM_TIMEOUT < 1) || (MEM_TIMEOUT > 255)) begin : g_bad_mem_timeout
            $error("mc_control_fsm: MEM_TIMEOUT must lie in 1..255");
        end
    endgenerate

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR1    = 4'd11,
        S_JALR2    = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // Last wait-cycle index before a stalled access is declared dead.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_reg, state_next;
    logic [7:0] wait_cnt_reg, wait_cnt_next;

    logic       mem_read, mem_write, adr_src;
    logic       ir_write, pc_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] imm_src;
    logic [3:0] alu_code;
    logic       mem_state;
    logic       timed_out;
    logic       branch_cond;
    logic       branch_taken;
    logic       branch_legal;

    // sub_ok distinguishes R-type (funct7b5 picks sub) from I-type (only shifts use it).
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7b5,
                                              input logic sub_ok);
        logic [3:0] code;
        code = ALU_ADD;
        unique case (f3)
            3'b000:  code = (sub_ok && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

    assign mem_state = (state_reg == S_FETCH) || (state_reg == S_MEMREAD) ||
                       (state_reg == S_MEMWRITE);
    assign timed_out = !bus.mem_ready && (wait_cnt_reg == WAIT_LAST);

    // funct3[2:1] picks the flag, funct3[0] inverts it; 010/011 have no branch meaning.
    always_comb begin
        branch_cond = bus.Zero;
        unique case (bus.funct3[2:1])
            2'b10:   branch_cond = bus.Lt;
            2'b11:   branch_cond = bus.Ltu;
            default: branch_cond = bus.Zero;
        endcase
    end
    assign branch_legal = (bus.funct3[2:1] != 2'b01);
    assign branch_taken = branch_legal && (branch_cond ^ bus.funct3[0]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_FETCH;
            wait_cnt_reg <= 8'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Any state change clears the counter, which covers entry into every memory state.
    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (state_next != state_reg) begin
            wait_cnt_next = 8'd0;
        end else if (mem_state && !bus.mem_ready) begin
            wait_cnt_next = wait_cnt_reg + 8'd1;
        end
    end

    always_comb begin
        state_next = state_reg;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        imm_src    = IMM_I;
        alu_code   = ALU_ADD;

        // Outputs are gated by reset so an abandoned access drops its request at once.
        if (reset) begin
            unique case (state_reg)
                S_FETCH: begin
                    mem_read = 1'b1;
                    if (bus.mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        alu_src_b  = SRCB_FOUR;
                        result_src = RES_ALURES;
                        state_next = S_DECODE;
                    end else if (timed_out) begin
                        state_next = S_TRAP;
                    end
                end
                S_DECODE: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                    imm_src   = IMM_B;
                    unique case (bus.op)
                        OP_LOAD, OP_STORE: state_next = S_MEMADR;
                        OP_REG:            state_next = S_EXECR;
                        OP_IMM:            state_next = S_EXECI;
                        OP_BRANCH:         state_next = S_BRANCH;
                        OP_JAL:            state_next = S_JAL;
                        OP_JALR:           state_next = S_JALR1;
                        OP_LUI:            state_next = S_LUI;
                        OP_AUIPC:          state_next = S_AUIPC;
                        default:           state_next = S_TRAP;
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    if (bus.op == OP_STORE) begin
                        imm_src    = IMM_S;
                        state_next = S_MEMWRITE;
                    end else begin
                        imm_src    = IMM_I;
                        state_next = S_MEMREAD;
                    end
                end
                S_MEMREAD: begin
                    mem_read = 1'b1;
                    adr_src  = 1'b1;
                    if (bus.mem_ready) begin
                        state_next = S_MEMWB;
                    end else if (timed_out) begin
                        state_next = S_TRAP;
                    end
                end
                S_MEMWRITE: begin
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                    if (bus.mem_ready) begin
                        state_next = S_FETCH;
                    end else if (timed_out) begin
                        state_next = S_TRAP;
                    end
                end
                S_MEMWB: begin
                    result_src = RES_DATA;
                    reg_write  = 1'b1;
                    state_next = S_FETCH;
                end
                S_EXECR: begin
                    alu_src_a  = SRCA_RS1;
                    alu_src_b  = SRCB_RS2;
                    alu_code   = alu_decode(bus.funct3, bus.funct7b5, 1'b1);
                    state_next = S_ALUWB;
                end
                S_EXECI: begin
                    alu_src_a  = SRCA_RS1;
                    alu_src_b  = SRCB_IMM;
                    alu_code   = alu_decode(bus.funct3, bus.funct7b5, 1'b0);
                    state_next = S_ALUWB;
                end
                S_ALUWB: begin
                    result_src = RES_ALUOUT;
                    reg_write  = 1'b1;
                    state_next = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a  = SRCA_RS1;
                    alu_src_b  = SRCB_RS2;
                    alu_code   = ALU_SUB;
                    result_src = RES_ALUOUT;
                    pc_write   = branch_taken;
                    state_next = branch_legal ? S_FETCH : S_TRAP;
                end
                S_JAL, S_JALR2: begin
                    alu_src_a  = SRCA_OLDPC;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALUOUT;
                    pc_write   = 1'b1;
                    imm_src    = IMM_J;
                    state_next = S_ALUWB;
                end
                S_JALR1: begin
                    alu_src_a  = SRCA_RS1;
                    alu_src_b  = SRCB_IMM;
                    imm_src    = IMM_I;
                    state_next = S_JALR2;
                end
                S_LUI, S_AUIPC: begin
                    alu_src_a  = (state_reg == S_LUI) ? SRCA_ZERO : SRCA_OLDPC;
                    alu_src_b  = SRCB_IMM;
                    imm_src    = IMM_U;
                    alu_code   = ALU_ADD;
                    state_next = S_ALUWB;
                end
                default: begin
                    state_next = S_TRAP;
                end
            endcase
        end
    end

    assign bus.MemRead    = mem_read;
    assign bus.MemWrite   = mem_write;
    assign bus.AdrSrc     = adr_src;
    assign bus.IRWrite    = ir_write;
    assign bus.PCWrite    = pc_write;
    assign bus.RegWrite   = reg_write;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ImmSrc     = imm_src;
    assign bus.ALUControl = ALUCTRL_W'(alu_code);
    assign bus.trap       = reset && (state_reg == S_TRAP);
    assign bus.state_o    = state_reg;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed instruction table plus random instruction stream,
// each checked cycle by cycle against a sequence model built from the instruction semantics.
module tb_mc_control_fsm;

    localparam int TMO = 4;

    localparam int ST_FETCH = 0,  ST_DECODE = 1,  ST_MEMADR = 2,  ST_MEMREAD = 3;
    localparam int ST_MEMWB = 4,  ST_MEMWRITE = 5, ST_EXECR = 6,  ST_EXECI = 7;
    localparam int ST_ALUWB = 8,  ST_BRANCH = 9,  ST_JAL = 10,    ST_JALR1 = 11;
    localparam int ST_JALR2 = 12, ST_LUI = 13,    ST_AUIPC = 14,  ST_TRAP = 15;

    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_REG = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

    // ALU code for each funct3 before the funct7b5 refinements.
    localparam logic [3:0] ALU_BY_F3 [0:7] = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};

    typedef struct packed {
        logic       mr, mw, adr, irw, pcw, rgw;
        logic [1:0] rs, sa, sb;
        logic [2:0] imm;
        logic [3:0] alu;
        logic       trap;
        logic [3:0] st;
    } ctrl_t;

    typedef struct packed {
        logic  rdy;
        ctrl_t c;
    } cyc_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7, z, lt, ltu;
        int         df, dm;
    } instr_t;

    typedef struct {
        instr_t in;
        int     n_cyc, rgw, pcw, mr;
        bit     trap;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    cyc_t exp_q[$];
    vec_t tbl[16];

    always #5 clk = ~clk;

    mc_control_fsm_if #(.ALUCTRL_W(4)) bus ();

    mc_control_fsm #(.ALUCTRL_W(4), .MEM_TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic ctrl_t idle(input int st);
        ctrl_t c;
        c      = '0;
        c.st   = 4'(st);
        c.trap = (st == ST_TRAP);
        return c;
    endfunction

    function automatic ctrl_t observe();
        ctrl_t c;
        c.mr   = bus.MemRead;   c.mw  = bus.MemWrite; c.adr = bus.AdrSrc;
        c.irw  = bus.IRWrite;   c.pcw = bus.PCWrite;  c.rgw = bus.RegWrite;
        c.rs   = bus.ResultSrc; c.sa  = bus.ALUSrcA;  c.sb  = bus.ALUSrcB;
        c.imm  = bus.ImmSrc;    c.alu = bus.ALUControl;
        c.trap = bus.trap;      c.st  = bus.state_o;
        return c;
    endfunction

    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic f7, input bit r_type);
        logic [3:0] r;
        r = ALU_BY_F3[f3];
        if (f3 == 3'd0 && r_type && f7) r = 4'd1;
        if (f3 == 3'd5 && f7) r = 4'd9;
        return r;
    endfunction

    function automatic bit br_taken(input logic [2:0] f3, input logic z, lt, ltu);
        bit cond;
        cond = f3[2] ? (f3[1] ? ltu : lt) : z;
        return f3[0] ? !cond : cond;
    endfunction

    function automatic instr_t mk(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                  input logic z, lt, ltu, input int df, dm);
        instr_t i;
        i.op = op; i.f3 = f3; i.f7 = f7; i.z = z; i.lt = lt; i.ltu = ltu; i.df = df; i.dm = dm;
        return i;
    endfunction

    task automatic push(input logic rdy, input ctrl_t c);
        cyc_t e;
        e.rdy = rdy;
        e.c   = c;
        exp_q.push_back(e);
    endtask

    // Non-memory cycle: mem_ready is noise the controller must ignore.
    task automatic push_any(input ctrl_t c);
        push(1'($urandom_range(0, 1)), c);
    endtask

    task automatic push_mem(input ctrl_t wait_c, input ctrl_t done_c, input int delay,
                            output bit ok);
        int n;
        n = (delay >= TMO) ? TMO : delay;
        for (int i = 0; i < n; i++) push(1'b0, wait_c);
        ok = (delay < TMO);
        if (ok) push(1'b1, done_c);
    endtask

    task automatic push_trap();
        push_any(idle(ST_TRAP));
        push_any(idle(ST_TRAP));
    endtask

    task automatic push_wb();
        ctrl_t c;
        c = idle(ST_ALUWB); c.rgw = 1'b1;
        push_any(c);
    endtask

    function automatic ctrl_t jal_ctrl(input int st);
        ctrl_t c;
        c = idle(st); c.sa = 2'b01; c.sb = 2'b10; c.pcw = 1'b1; c.imm = 3'b011;
        return c;
    endfunction

    // Expected cycle sequence of one instruction, from fetch to the next fetch or trap.
    task automatic model(input instr_t in);
        ctrl_t c, d;
        bit    ok;
        c = idle(ST_FETCH); c.mr = 1'b1;
        d = c; d.irw = 1'b1; d.pcw = 1'b1; d.sb = 2'b10; d.rs = 2'b10;
        push_mem(c, d, in.df, ok);
        if (!ok) begin push_trap(); return; end
        c = idle(ST_DECODE); c.sa = 2'b01; c.sb = 2'b01; c.imm = 3'b010;
        push_any(c);
        case (in.op)
            OP_LOAD, OP_STORE: begin
                c = idle(ST_MEMADR); c.sa = 2'b10; c.sb = 2'b01;
                c.imm = (in.op == OP_STORE) ? 3'b001 : 3'b000;
                push_any(c);
                if (in.op == OP_LOAD) begin
                    c = idle(ST_MEMREAD); c.mr = 1'b1; c.adr = 1'b1;
                    push_mem(c, c, in.dm, ok);
                    if (!ok) begin push_trap(); return; end
                    c = idle(ST_MEMWB); c.rs = 2'b01; c.rgw = 1'b1;
                    push_any(c);
                end else begin
                    c = idle(ST_MEMWRITE); c.mw = 1'b1; c.adr = 1'b1;
                    push_mem(c, c, in.dm, ok);
                    if (!ok) begin push_trap(); return; end
                end
            end
            OP_REG: begin
                c = idle(ST_EXECR); c.sa = 2'b10; c.alu = alu_of(in.f3, in.f7, 1'b1);
                push_any(c); push_wb();
            end
            OP_IMM: begin
                c = idle(ST_EXECI); c.sa = 2'b10; c.sb = 2'b01; c.alu = alu_of(in.f3, in.f7, 1'b0);
                push_any(c); push_wb();
            end
            OP_BR: begin
                c = idle(ST_BRANCH); c.sa = 2'b10; c.alu = 4'd1;
                if (in.f3 == 3'd2 || in.f3 == 3'd3) begin
                    push_any(c); push_trap();
                end else begin
                    c.pcw = br_taken(in.f3, in.z, in.lt, in.ltu);
                    push_any(c);
                end
            end
            OP_JAL: begin
                push_any(jal_ctrl(ST_JAL)); push_wb();
            end
            OP_JALR: begin
                c = idle(ST_JALR1); c.sa = 2'b10; c.sb = 2'b01;
                push_any(c); push_any(jal_ctrl(ST_JALR2)); push_wb();
            end
            OP_LUI, OP_AUIPC: begin
                c = idle((in.op == OP_LUI) ? ST_LUI : ST_AUIPC);
                c.sa = (in.op == OP_LUI) ? 2'b11 : 2'b01; c.sb = 2'b01; c.imm = 3'b100;
                push_any(c); push_wb();
            end
            default: push_trap();
        endcase
    endtask

    task automatic check_ctrl(input string name, input ctrl_t want);
        ctrl_t got;
        got = observe();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic run_instr(input string name, input instr_t in, input int max_cyc,
                             output int n_cyc, rgw_n, pcw_n, mr_n, output bit trap_seen);
        cyc_t  e;
        ctrl_t got;
        int    k;
        n_cyc = 0; rgw_n = 0; pcw_n = 0; mr_n = 0; trap_seen = 1'b0; k = 0;
        exp_q.delete();
        model(in);
        while (exp_q.size() > 0 && k < max_cyc) begin
            e = exp_q.pop_front();
            @(negedge clk);
            if (k == 0) begin
                bus.op = in.op; bus.funct3 = in.f3; bus.funct7b5 = in.f7;
                bus.Zero = in.z; bus.Lt = in.lt; bus.Ltu = in.ltu;
            end
            bus.mem_ready = e.rdy;
            #1;
            got = observe();
            check_ctrl($sformatf("%s cyc%0d", name, k), e.c);
            if (got.trap) trap_seen = 1'b1; else n_cyc++;
            rgw_n += int'(got.rgw); pcw_n += int'(got.pcw); mr_n += int'(got.mr);
            k++;
        end
        exp_q.delete();
        $display("instr %s op=%b f3=%0d df=%0d dm=%0d cycles=%0d trap=%0b", name, in.op, in.f3,
                 in.df, in.dm, n_cyc, trap_seen);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1 check_ctrl("reset_hold0", idle(ST_FETCH));
        @(negedge clk);
        #1 check_ctrl("reset_hold1", idle(ST_FETCH));
        @(posedge clk);
        #1 reset = 1'b1;
        bus.mem_ready = 1'b0;
    endtask

    task automatic set_vec(input int i, input instr_t in, input int n, r, p, m, input bit t);
        tbl[i].in = in; tbl[i].n_cyc = n; tbl[i].rgw = r; tbl[i].pcw = p; tbl[i].mr = m;
        tbl[i].trap = t;
    endtask

    initial begin
        int n, r, p, m;
        bit t;
        instr_t in;
        logic [6:0] ops [0:8];

        ops = '{OP_LOAD, OP_STORE, OP_REG, OP_IMM, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

        //          instruction                            cyc rgw pcw mr trap
        set_vec(0,  mk(OP_REG,   3'd0, 0, 0, 0, 0, 0, 0),   4, 1, 1, 1, 0); // add
        set_vec(1,  mk(OP_LOAD,  3'd2, 0, 0, 0, 0, 3, 3),  11, 1, 1, 8, 0); // lw, slow memory
        set_vec(2,  mk(OP_BR,    3'd1, 0, 1, 0, 0, 0, 0),   3, 0, 1, 1, 0); // bne not taken
        set_vec(3,  mk(OP_BR,    3'd1, 0, 0, 0, 0, 0, 0),   3, 0, 2, 1, 0); // bne taken
        set_vec(4,  mk(OP_BR,    3'd6, 0, 0, 0, 1, 0, 0),   3, 0, 2, 1, 0); // bltu taken
        set_vec(5,  mk(OP_STORE, 3'd2, 0, 0, 0, 0, 0, 2),   6, 0, 1, 1, 0); // sw
        set_vec(6,  mk(OP_JAL,   3'd0, 0, 0, 0, 0, 1, 0),   5, 1, 2, 2, 0); // jal
        set_vec(7,  mk(OP_JALR,  3'd0, 0, 0, 0, 0, 0, 0),   5, 1, 2, 1, 0); // jalr
        set_vec(8,  mk(OP_LUI,   3'd0, 0, 0, 0, 0, 0, 0),   4, 1, 1, 1, 0); // lui
        set_vec(9,  mk(7'h7f,    3'd0, 0, 0, 0, 0, 0, 0),   2, 0, 1, 1, 1); // illegal op
        set_vec(10, mk(OP_BR,    3'd2, 0, 0, 0, 0, 0, 0),   3, 0, 1, 1, 1); // illegal branch
        set_vec(11, mk(OP_STORE, 3'd2, 0, 0, 0, 0, 0, 4),   7, 0, 1, 1, 1); // store timeout
        set_vec(12, mk(OP_LOAD,  3'd2, 0, 0, 0, 0, 0, 3),   8, 1, 1, 5, 0); // ready on last cycle
        set_vec(13, mk(OP_REG,   3'd0, 0, 0, 0, 0, 4, 0),   4, 0, 0, 4, 1); // fetch timeout
        set_vec(14, mk(OP_IMM,   3'd5, 1, 0, 0, 0, 0, 0),   4, 1, 1, 1, 0); // srai
        set_vec(15, mk(OP_REG,   3'd0, 1, 0, 0, 0, 0, 0),   4, 1, 1, 1, 0); // sub

        bus.mem_ready = 1'b0; bus.op = '0; bus.funct3 = '0; bus.funct7b5 = 1'b0;
        bus.Zero = 1'b0; bus.Lt = 1'b0; bus.Ltu = 1'b0;
        #1 check_ctrl("reset_state", idle(ST_FETCH));
        repeat (2) @(negedge clk);
        bus.mem_ready = 1'b1;
        #1 check_ctrl("reset_ignores_ready", idle(ST_FETCH));
        @(posedge clk);
        #1 reset = 1'b1;
        bus.mem_ready = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_instr($sformatf("vec%0d", i), tbl[i].in, 1000, n, r, p, m, t);
            check_int($sformatf("vec%0d cycles", i), n, tbl[i].n_cyc);
            check_int($sformatf("vec%0d regwrite", i), r, tbl[i].rgw);
            check_int($sformatf("vec%0d pcwrite", i), p, tbl[i].pcw);
            check_int($sformatf("vec%0d memread", i), m, tbl[i].mr);
            check_int($sformatf("vec%0d trap", i), int'(t), int'(tbl[i].trap));
            if (t) do_reset();
        end

        for (int i = 0; i < 150; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            in.op  = (sel == 9) ? 7'($urandom) : ops[sel];
            in.f3  = 3'($urandom); in.f7 = 1'($urandom);
            in.z   = 1'($urandom); in.lt = 1'($urandom); in.ltu = 1'($urandom);
            in.df  = ($urandom_range(0, 9) == 0) ? TMO + $urandom_range(0, 1) : $urandom_range(0, 3);
            in.dm  = ($urandom_range(0, 9) == 0) ? TMO + $urandom_range(0, 1) : $urandom_range(0, 3);
            run_instr($sformatf("rnd%0d", i), in, 1000, n, r, p, m, t);
            if (t) do_reset();
        end

        // Store stalled in MEMWRITE, then reset pulled mid-cycle: outputs must drop with no edge.
        run_instr("sw_abandon", mk(OP_STORE, 3'd2, 0, 0, 0, 0, 0, 10), 5, n, r, p, m, t);
        #1 reset = 1'b0;
        #1 check_ctrl("async_reset_clear", idle(ST_FETCH));
        @(negedge clk);
        #1 check_ctrl("async_reset_hold", idle(ST_FETCH));
        @(posedge clk);
        #1 reset = 1'b1;
        run_instr("resume_add", tbl[0].in, 1000, n, r, p, m, t);
        check_int("resume cycles", n, 4);
        check_int("resume regwrite", r, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
